sync_arith_unit_seq: RTL
========================

// Module: sync_arith_unit_seq
// PURPOSE
//  Parametrised successor of the team's 2-bit-opcode synchronous arithmetic unit.
//  - Executes SHIFT, ADD, DIV and ABS (two's-complement magnitude) on M-bit operands.
//  - Uses a valid/ready input handshake and a one-cycle o_valid result strobe.
//  - DIV is a multi-cycle restoring divider that also returns the remainder.
//  - Sits between the operand register file and the writeback stage.
// PARAMETERS
//  M        8   operand/result width; legal range 2..32
//  SH_W     $clog2(M)+1   width of the shift amount taken from i_arg_B[SH_W-1:0]
// PORTS
//  i_clk        in   1    single clock, rising edge
//  i_reset      in   1    asynchronous reset, active-high
//  i_valid      in   1    operation request; accepted when i_valid && o_ready
//  i_op         in   2    00 SHIFT, 01 ADD, 10 DIV, 11 ABS
//  i_arg_A      in   M    operand A
//  i_arg_B      in   M    operand B
//  o_ready      out  1    unit can accept a request this cycle
//  o_valid      out  1    one-cycle strobe: o_result/o_remainder/o_status valid
//  o_result     out  M    result; held until the next o_valid
//  o_remainder  out  M    DIV remainder; 0 for other ops
//  o_status     out  4    [3] ERROR, [2] ONES, [1] ZEROS, [0] OVERFLOW
// BEHAVIOUR
//  - Reset (async, while i_reset=1):
//    - o_valid=0, o_ready=1, o_result=0, o_remainder=0, o_status=0, FSM=IDLE.
//    - Reset during a DIV aborts it; no o_valid is issued for the aborted op.
//  - FSM states: IDLE, DIV_RUN, DIV_DONE.
//    - IDLE: o_ready=1.
//      - Accepted SHIFT/ADD/ABS: registered next edge, o_valid=1, stays in IDLE.
//        Throughput is 1 op/cycle.
//      - Accepted DIV with B!=0: goes to DIV_RUN, loads count=M.
//    - DIV_RUN: o_ready=0; one quotient bit per cycle, MSB first; count decrements.
//      - At count==1 goes to DIV_DONE.
//      - i_valid is ignored while here.
//    - DIV_DONE: drives o_valid=1, o_ready=1, returns to IDLE.
//      - A request accepted in this cycle is processed as if from IDLE.
//  - Latency (accept edge to o_valid high):
//    - SHIFT/ADD/ABS and DIV-by-zero: 1 cycle.
//    - DIV: M+1 cycles.
//  - SHIFT: logical right shift of A by i_arg_B[SH_W-1:0], taken as unsigned.
//    - If $signed(i_arg_B)<0: ERROR=1, result=0.
//    - If the amount is >=M: result=0, no error.
//  - ADD: result = (A+B) mod 2^M.
//    - OVERFLOW=1 when A[M-1]==B[M-1] and result[M-1]!=A[M-1] (signed overflow).
//  - DIV: unsigned; result=A/B, remainder=A%B.
//    - B==0: ERROR=1, result=0, remainder=0, 1-cycle latency, no DIV_RUN.
//  - ABS: result = A[M-1] ? -A : A.
//    - A==2^(M-1): result=2^(M-1), OVERFLOW=1.
//  - Flags:
//    - ZEROS=1 iff the result being delivered is 0, ERROR cases included.
//    - ONES=1 iff the result is all ones.
//  - Flags are computed from the new result, never the previous one.
//  - o_status is updated only with o_valid; otherwise it holds its value.
//  - Outputs never carry X.
// STRUCTURE
//  - Package arith_seq_pkg:
//    - op_t enum {OP_SHIFT, OP_ADD, OP_DIV, OP_ABS};
//    - status bit localparams ST_ERROR=3, ST_ONES=2, ST_ZEROS=1, ST_OVERFLOW=0;
//    - state_t enum {IDLE, DIV_RUN, DIV_DONE}.
//  - Sub-module seq_divider #(M):
//    - ports: start, dividend, divisor, busy, done, quotient, remainder;
//    - restoring algorithm, M iterations, on the same i_clk/i_reset.
//  - The top level holds the FSM, single-cycle datapath, flag logic and output registers.
// TESTING (M=8)
//  1. Reset asserted mid-DIV (A=200, B=7, 3 cycles in) -> o_valid never pulses; o_ready=1.
//     Next DIV completes normally.
//  2. ADD A=0x7F, B=0x01 -> result 0x80, status 0001.
//     ADD A=0xFF, B=0x01 -> result 0x00, status 0010.
//  3. DIV A=200, B=7 -> o_ready low for 8 cycles; o_valid 9 cycles after accept.
//     Result 28, remainder 4, status 0000.
//     DIV B=0 -> next cycle result 0, status 1010.
//  4. SHIFT A=0xF0, B=4 -> 0x0F.
//     B=9 -> 0x00, status 0010.
//     B=0x80 -> ERROR, status 1010.
//  5. ABS A=0x80 -> result 0x80, OVERFLOW=1.
//     ABS A=0xFB -> 0x05.
//     ABS A=0xFF -> 0x01.
//  6. Back-to-back ADD/SHIFT/ABS, i_valid held high -> o_valid on 3 consecutive cycles.
//     A request during DIV_RUN is ignored; a request in DIV_DONE is accepted.

Source files
------------

// File: rtl/sync_arith_unit_seq_pkg.sv
// Shared types and status-bit positions for the sequential arithmetic unit
// and its restoring divider.
package arith_seq_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT = 2'b00,
    OP_ADD   = 2'b01,
    OP_DIV   = 2'b10,
    OP_ABS   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DIV_RUN  = 2'b01,
    DIV_DONE = 2'b10
  } state_t;

  localparam int ST_ERROR    = 3;
  localparam int ST_ONES     = 2;
  localparam int ST_ZEROS    = 1;
  localparam int ST_OVERFLOW = 0;

endpackage

// File: rtl/sync_arith_unit_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// done/quotient/remainder are combinational on the final iteration.
module seq_divider #(
  parameter int M = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] quotient,
  output logic [M-1:0] remainder
);

  localparam int CNT_W = $clog2(M + 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [M-1:0]     rem_p0;
  logic [M-1:0]     quo_p0;
  logic [M-1:0]     div_p0;
  logic [M-1:0]     rem_nx;
  logic [M-1:0]     quo_nx;
  logic [M:0]       trial;

  // Partial remainder shifted with the next dividend bit, then trial subtract.
  always_comb begin
    trial  = {rem_p0, quo_p0[M-1]} - {1'b0, div_p0};
    rem_nx = {rem_p0[M-2:0], quo_p0[M-1]};
    quo_nx = {quo_p0[M-2:0], 1'b0};
    if (!trial[M]) begin
      rem_nx = trial[M-1:0];
      quo_nx = {quo_p0[M-2:0], 1'b1};
    end
  end

  assign done      = busy && (cnt_p0 == CNT_W'(1));
  assign quotient  = quo_nx;
  assign remainder = rem_nx;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy   <= 1'b0;
      cnt_p0 <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt_p0 <= CNT_W'(M);
    end else if (busy) begin
      cnt_p0 <= cnt_p0 - CNT_W'(1);
      if (cnt_p0 == CNT_W'(1)) busy <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (start) begin
      rem_p0 <= '0;
      quo_p0 <= dividend;
      div_p0 <= divisor;
    end else if (busy) begin
      rem_p0 <= rem_nx;
      quo_p0 <= quo_nx;
    end
  end

endmodule

// File: rtl/sync_arith_unit_seq.sv
// Sequential arithmetic unit: single-cycle SHIFT/ADD/ABS, multi-cycle DIV,
// valid/ready request handshake and a one-cycle result strobe.
module sync_arith_unit_seq
  import arith_seq_pkg::*;
#(
  parameter int M    = 8,
  parameter int SH_W = $clog2(M) + 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  input  logic [1:0]   i_op,
  input  logic [M-1:0] i_arg_A,
  input  logic [M-1:0] i_arg_B,
  output logic         o_ready,
  output logic         o_valid,
  output logic [M-1:0] o_result,
  output logic [M-1:0] o_remainder,
  output logic [3:0]   o_status
);

  localparam logic [M-1:0] MIN_NEG = {1'b1, {(M-1){1'b0}}};

  state_t       state;
  state_t       state_nx;
  op_t          op;
  logic         accept;
  logic         div_go;
  logic         div_busy;
  logic         div_done;
  logic [M-1:0] div_quo;
  logic [M-1:0] div_rem;
  logic [M-1:0] comb_res;
  logic         comb_err;
  logic         comb_ovf;

  function automatic logic [M-1:0] shift_right(input logic [M-1:0] a,
                                               input logic [SH_W-1:0] amt);
    if (int'(amt) >= M) return '0;
    return a >> amt;
  endfunction

  function automatic logic add_overflow(input logic signed [M-1:0] a,
                                        input logic signed [M-1:0] b,
                                        input logic signed [M-1:0] s);
    return (a[M-1] == b[M-1]) && (s[M-1] != a[M-1]);
  endfunction

  function automatic logic [M-1:0] abs_mag(input logic signed [M-1:0] a);
    logic signed [M-1:0] neg;
    neg = ~a + {{(M-1){1'b0}}, 1'b1};
    return a[M-1] ? neg : a;
  endfunction

  function automatic logic [3:0] make_status(input logic err, input logic ovf,
                                             input logic [M-1:0] res);
    logic [3:0] st;
    st              = '0;
    st[ST_ERROR]    = err;
    st[ST_ONES]     = &res;
    st[ST_ZEROS]    = (res == '0);
    st[ST_OVERFLOW] = ovf;
    return st;
  endfunction

  assign op      = op_t'(i_op);
  assign o_ready = (state != DIV_RUN);
  assign accept  = i_valid && o_ready;
  assign div_go  = accept && (op == OP_DIV) && (i_arg_B != '0);

  seq_divider #(.M(M)) u_div (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .start     (div_go),
    .dividend  (i_arg_A),
    .divisor   (i_arg_B),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DIV_DONE: state_nx = div_go ? DIV_RUN : IDLE;
      DIV_RUN: begin
        // Falling back to IDLE if the divider ever stops without done.
        if (div_done)       state_nx = DIV_DONE;
        else if (!div_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Single-cycle datapath; the DIV leg only covers divide-by-zero.
  always_comb begin
    comb_res = '0;
    comb_err = 1'b0;
    comb_ovf = 1'b0;
    case (op)
      OP_SHIFT: begin
        if (i_arg_B[M-1]) comb_err = 1'b1;
        else              comb_res = shift_right(i_arg_A, i_arg_B[SH_W-1:0]);
      end
      OP_ADD: begin
        comb_res = i_arg_A + i_arg_B;
        comb_ovf = add_overflow(i_arg_A, i_arg_B, comb_res);
      end
      OP_DIV: comb_err = (i_arg_B == '0);
      OP_ABS: begin
        comb_res = abs_mag(i_arg_A);
        comb_ovf = (i_arg_A == MIN_NEG);
      end
      default: ;
    endcase
  end

  // Output register stage: results and status update only with o_valid.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_remainder <= '0;
      o_status    <= '0;
    end else begin
      o_valid <= 1'b0;
      if (state == DIV_RUN) begin
        if (div_done) begin
          o_valid     <= 1'b1;
          o_result    <= div_quo;
          o_remainder <= div_rem;
          o_status    <= make_status(1'b0, 1'b0, div_quo);
        end
      end else if (accept && !div_go) begin
        o_valid     <= 1'b1;
        o_result    <= comb_res;
        o_remainder <= '0;
        o_status    <= make_status(comb_err, comb_ovf, comb_res);
      end
    end
  end

endmodule
